// File: rtl/micro_sequencer.sv
// EV21 microprogram sequencer: opcode -> writable dispatch table -> writable
// microcode routine, one control word per cycle with register-field substitution.
module micro_sequencer #(
  parameter int INSTR_W = 22,
  parameter int OPC_W   = 6,
  parameter int CW_W    = 33,
  parameter int UADDR_W = 6,
  parameter int FIELD_W = 5,
  parameter int C_LSB   = 12,
  parameter int ADDR_W  = 11,
  parameter logic [CW_W-1:0] NOP_CW = 33'h1E08E3003
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 uop_valid,
  output logic [CW_W-1:0]      micro_word,
  output logic [ADDR_W-1:0]    data_addr,
  input  logic                 cfg_sel,
  input  logic                 cfg_we,
  input  logic [((UADDR_W > OPC_W) ? UADDR_W : OPC_W)-1:0] cfg_addr,
  input  logic [CW_W+2:0]      cfg_wdata,
  output logic                 ucode_err
);

  localparam int UW    = CW_W + 3;
  localparam int C_W   = 6;
  localparam int DEPTH = 2 ** UADDR_W;
  localparam int NDISP = 2 ** OPC_W;
  localparam logic [UW-1:0] UCODE_RST = {1'b1, 1'b0, 1'b0, NOP_CW};

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [UADDR_W-1:0]   upc_q, upc_d;
  // Only the register fields of the instruction are ever read back.
  logic [2*FIELD_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]    daddr_q, daddr_d;
  logic                 err_q, err_d;
  logic [UADDR_W-1:0]   dispatch_q [NDISP];
  logic [UW-1:0]        ucode_q [DEPTH];

  logic [UW-1:0]    word_s;
  logic             last_s, sub_a_s, sub_c_s;
  logic [OPC_W-1:0] opcode_s;
  logic             ready_s, accept_s, cfg_ok_s;
  logic [CW_W-1:0]  subst_s;
  logic             uop_valid_s;
  logic [CW_W-1:0]  micro_word_s;
  logic             unused_s;

  assign word_s   = ucode_q[upc_q];
  assign last_s   = word_s[UW-1];
  assign sub_c_s  = word_s[UW-2];
  assign sub_a_s  = word_s[UW-3];
  assign opcode_s = instr[INSTR_W-1 -: OPC_W];
  assign ready_s  = rst_n & ~hold & ((state_q == IDLE) | ((state_q == EXEC) & last_s));
  assign accept_s = instr_valid & ready_s;
  assign cfg_ok_s = cfg_we & (state_q == IDLE) & ~accept_s;
  assign unused_s = ^instr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values: accept, advance, overflow abort.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    instr_d = instr_q;
    daddr_d = daddr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
          upc_d   = dispatch_q[opcode_s];
          instr_d = instr[2*FIELD_W-1:0];
          daddr_d = instr[ADDR_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (hold) begin
          state_d = EXEC;
        end else if (last_s) begin
          if (accept_s) begin
            state_d = EXEC;
            upc_d   = dispatch_q[opcode_s];
            instr_d = instr[2*FIELD_W-1:0];
            daddr_d = instr[ADDR_W-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (upc_q == {UADDR_W{1'b1}}) begin
          // Running off the end of the store aborts rather than wrapping.
          err_d   = 1'b1;
          upc_d   = {UADDR_W{1'b0}};
          state_d = IDLE;
        end else begin
          upc_d = upc_q + UADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Field substitution into the Bus_A and Bus_C slots.
  always_comb begin
    subst_s = word_s[CW_W-1:0];
    if (sub_a_s) begin
      subst_s[FIELD_W-1:0] = instr_q[FIELD_W-1:0];
    end else begin
      subst_s[FIELD_W-1:0] = word_s[FIELD_W-1:0];
    end
    if (sub_c_s) begin
      subst_s[C_LSB +: C_W] = C_W'(instr_q[2*FIELD_W-1:FIELD_W]);
    end else begin
      subst_s[C_LSB +: C_W] = word_s[C_LSB +: C_W];
    end
  end

  // Output decode from state.
  always_comb begin
    uop_valid_s  = 1'b0;
    micro_word_s = NOP_CW;
    case (state_q)
      IDLE: begin
        uop_valid_s  = 1'b0;
        micro_word_s = NOP_CW;
      end
      EXEC: begin
        uop_valid_s  = 1'b1;
        micro_word_s = subst_s;
      end
      default: begin
        uop_valid_s  = 1'b0;
        micro_word_s = NOP_CW;
      end
    endcase
  end

  // Sequencer datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q   <= {UADDR_W{1'b0}};
      instr_q <= {(2*FIELD_W){1'b0}};
      daddr_q <= {ADDR_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      instr_q <= instr_d;
      daddr_q <= daddr_d;
      err_q   <= err_d;
    end
  end

  // Dispatch table; upper cfg_addr bits beyond OPC_W are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDISP; i++) begin
        dispatch_q[i] <= {UADDR_W{1'b0}};
      end
    end else if (cfg_ok_s && cfg_sel) begin
      dispatch_q[cfg_addr[OPC_W-1:0]] <= cfg_wdata[UADDR_W-1:0];
    end
  end

  // Microcode store; only written while idle with no acceptance in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ucode_q[i] <= UCODE_RST;
      end
    end else if (cfg_ok_s && !cfg_sel) begin
      ucode_q[cfg_addr[UADDR_W-1:0]] <= cfg_wdata;
    end
  end

  assign instr_ready = ready_s;
  assign uop_valid   = uop_valid_s;
  assign micro_word  = micro_word_s;
  assign data_addr   = daddr_q;
  assign ucode_err   = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, hand sequences for reset,
// and randomized traffic against a routine-level reference model.
module tb_micro_sequencer;

  localparam logic [32:0] NOP   = 33'h1E08E3003;
  localparam logic [32:0] CWA   = 33'h123456789;
  localparam logic [32:0] CWB   = 33'h0DEADBEEF;
  localparam logic [32:0] CWC   = 33'h1CAFEF00D;
  localparam logic [32:0] A_SUB = (CWA & ~33'h1F) | 33'h7;
  localparam logic [32:0] B_SUB = (CWB & ~(33'h3F << 12)) | (33'h3 << 12);

  logic        clk, rst_n, hold, instr_valid, instr_ready, uop_valid;
  logic [21:0] instr;
  logic [32:0] micro_word;
  logic [10:0] data_addr;
  logic        cfg_sel, cfg_we, ucode_err;
  logic [5:0]  cfg_addr;
  logic [35:0] cfg_wdata;

  int total = 0;
  int bad   = 0;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .uop_valid(uop_valid), .micro_word(micro_word), .data_addr(data_addr),
    .cfg_sel(cfg_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .ucode_err(ucode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tables plus the queue of words the current routine will emit.
  typedef struct { logic [32:0] cw; logic last; } ent_t;
  logic [5:0]  mdisp [64];
  logic [35:0] muc [64];
  ent_t        mq[$];
  logic [10:0] mdaddr;
  logic        merr;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mdisp[i] = 6'd0;
      muc[i]   = {3'b100, NOP};
    end
    mq.delete();
    mdaddr = 11'd0;
    merr   = 1'b0;
  endtask

  function automatic logic [32:0] subst(input logic [35:0] w, input logic [21:0] ins);
    logic [32:0] cw;
    cw = w[32:0];
    if (w[33]) cw[4:0] = ins[4:0];
    if (w[34]) cw[17:12] = {1'b0, ins[9:5]};
    return cw;
  endfunction

  task automatic build(input logic [21:0] ins);
    int   a;
    ent_t e;
    mq.delete();
    a = int'(mdisp[ins[21:16]]);
    for (int k = 0; k < 64; k++) begin
      e.cw   = subst(muc[a], ins);
      e.last = muc[a][35];
      mq.push_back(e);
      if (e.last || a == 63) break;
      a++;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: compare against the model before the edge, then advance the model.
  task automatic cycle();
    logic        er, ev, acc, cfg;
    logic [32:0] ew;
    #1;
    ev = (mq.size() != 0);
    ew = ev ? mq[0].cw : NOP;
    er = !hold && (!ev || (mq.size() == 1 && mq[0].last));
    check("m_ready", instr_ready, er);
    check("m_valid", uop_valid, ev);
    check("m_word", micro_word, ew);
    check("m_daddr", data_addr, mdaddr);
    check("m_err", ucode_err, merr);
    @(posedge clk);
    acc = instr_valid && er;
    cfg = !ev && !acc && cfg_we;
    if (ev && !hold) begin
      if (mq.size() == 1 && !mq[0].last) merr = 1'b1;
      void'(mq.pop_front());
    end
    if (acc) begin
      build(instr);
      mdaddr = instr[10:0];
    end
    if (cfg) begin
      if (cfg_sel) mdisp[cfg_addr] = cfg_wdata[5:0];
      else muc[cfg_addr] = cfg_wdata;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic h, input logic v, input logic [21:0] ins,
                       input logic we, input logic sel, input logic [5:0] ca,
                       input logic [35:0] wd);
    hold = h; instr_valid = v; instr = ins;
    cfg_we = we; cfg_sel = sel; cfg_addr = ca; cfg_wdata = wd;
  endtask

  typedef struct {
    logic h, v; logic [21:0] ins; logic we, sel; logic [5:0] ca; logic [35:0] wd;
    logic er, ev; logic [32:0] ew; logic ee;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic h, input logic v, input logic [21:0] ins,
                     input logic we, input logic sel, input logic [5:0] ca,
                     input logic [35:0] wd, input logic er, input logic ev,
                     input logic [32:0] ew, input logic ee);
    vec_t t;
    t.h = h; t.v = v; t.ins = ins; t.we = we; t.sel = sel; t.ca = ca; t.wd = wd;
    t.er = er; t.ev = ev; t.ew = ew; t.ee = ee;
    vecs.push_back(t);
  endtask

  initial begin
    // Reset defaults: opcode 0x20 runs the reset NOP word once.
    add(1'b0, 1'b1, 22'h200000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    // Programming in IDLE.
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 6'h18, 36'd4, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 6'h21, 36'd6, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 6'd4, {3'b001, CWA}, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 6'd5, {3'b010, CWB}, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 6'd6, {3'b100, CWC}, 1'b1, 1'b0, NOP, 1'b0);
    // Three-word routine; a cfg write during EXEC is dropped.
    add(1'b0, 1'b1, 22'h180067, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, A_SUB, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 6'h18, 36'd9, 1'b0, 1'b1, B_SUB, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, CWC, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    // Hold for 3 cycles on the second word, valid toggling underneath.
    add(1'b0, 1'b1, 22'h180067, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, A_SUB, 1'b0);
    add(1'b1, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, B_SUB, 1'b0);
    add(1'b1, 1'b1, 22'h200000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, B_SUB, 1'b0);
    add(1'b1, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, B_SUB, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, B_SUB, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, CWC, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    // Back-to-back one-word routines; cfg write with an accept is dropped.
    add(1'b0, 1'b1, 22'h200000, 1'b1, 1'b0, 6'd0, {3'b100, CWA}, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b1, 22'h210000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, CWC, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    // Overflow off the top of the store.
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 6'h3E, 36'd62, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 6'd62, {3'b000, CWB}, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 6'd63, {3'b000, CWA}, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b1, 22'h3E0000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, CWB, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b0, 1'b1, CWA, 1'b0);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b1);
    add(1'b0, 1'b1, 22'h200000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b0, NOP, 1'b1);
    add(1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 6'd0, 36'd0, 1'b1, 1'b1, NOP, 1'b1);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 22'h0, 1'b0, 1'b0, 6'd0, 36'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_valid", uop_valid, 1'b0);
    check("rst_word", micro_word, NOP);
    check("rst_daddr", data_addr, 11'h000);
    check("rst_err", ucode_err, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].h, vecs[i].v, vecs[i].ins, vecs[i].we, vecs[i].sel, vecs[i].ca, vecs[i].wd);
      #1;
      check($sformatf("row%0d_ready", i), instr_ready, vecs[i].er);
      check($sformatf("row%0d_valid", i), uop_valid, vecs[i].ev);
      check($sformatf("row%0d_word", i), micro_word, vecs[i].ew);
      check($sformatf("row%0d_err", i), ucode_err, vecs[i].ee);
      cycle();
    end

    // Reset asserted mid-routine.
    drive(1'b0, 1'b1, 22'h180067, 1'b0, 1'b0, 6'd0, 36'd0);
    cycle();
    drive(1'b0, 1'b0, 22'h0, 1'b0, 1'b0, 6'd0, 36'd0);
    check("daddr_067", data_addr, 11'h067);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", instr_ready, 1'b0);
    check("midrst_valid", uop_valid, 1'b0);
    check("midrst_word", micro_word, NOP);
    check("midrst_err", ucode_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 22'h180067, 1'b0, 1'b0, 6'd0, 36'd0);
    cycle();
    drive(1'b0, 1'b0, 22'h0, 1'b0, 1'b0, 6'd0, 36'd0);
    #1;
    check("postrst_valid", uop_valid, 1'b1);
    check("postrst_word", micro_word, NOP);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      hold        = ($urandom_range(0, 4) == 0);
      instr_valid = 1'($urandom);
      instr       = 22'($urandom);
      cfg_we      = ($urandom_range(0, 2) == 0);
      cfg_sel     = 1'($urandom);
      cfg_addr    = 6'($urandom);
      cfg_wdata   = r[35:0];
      cfg_wdata[35] = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
